id_ex_pipe_stage: RTL and testbench

- Parametrised ID->EX pipeline register.
- Carries register addresses, operands, immediate and a control bus between decode and execute.
- Adds a valid/ready handshake with a 2-entry skid buffer, so the upstream ready is fully registered.
- Adds a synchronous flush for branch/hazard squash and an asynchronous active-low reset.

---
 rtl/id_ex_pipe_stage.sv | 129 ++++++++++++
 tb/tb_id_ex_pipe_stage.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_stage.sv
// ID->EX pipeline register with valid/ready handshake, 2-entry skid buffer and synchronous flush.
// Optional build macro ID_EX_STATS_EN adds saturating issued/bubble/stall counters.
module id_ex_pipe_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 16,
  parameter int STAT_W = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              FLUSH,
  input  logic              ValidD,
  output logic              ReadyD,
  input  logic [REG_AW-1:0] RsD,
  input  logic [REG_AW-1:0] RtD,
  input  logic [REG_AW-1:0] RdD,
  input  logic [DATA_W-1:0] RD1,
  input  logic [DATA_W-1:0] RD2,
  input  logic [DATA_W-1:0] immediateD,
  input  logic [CTRL_W-1:0] CtrlD,
  output logic              ValidE,
  input  logic              ReadyE,
  output logic [REG_AW-1:0] RsE,
  output logic [REG_AW-1:0] RtE,
  output logic [REG_AW-1:0] RdE,
  output logic [DATA_W-1:0] RD1E,
  output logic [DATA_W-1:0] RD2E,
  output logic [DATA_W-1:0] immediateE,
  output logic [CTRL_W-1:0] CtrlE
`ifdef ID_EX_STATS_EN
  ,
  output logic [STAT_W-1:0] StatIssued,
  output logic [STAT_W-1:0] StatBubble,
  output logic [STAT_W-1:0] StatStall
`endif
);

  localparam int PAY_W = 3*REG_AW + 3*DATA_W + CTRL_W;

  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

  state_t             state_q, state_d;
  logic [PAY_W-1:0]   in_pay, m_pay, s_pay;
  logic               in_fire, out_fire;
  logic               load_m_in, load_m_skid, load_s;

  assign in_pay = {RsD, RtD, RdD, RD1, RD2, immediateD, CtrlD};
  assign {RsE, RtE, RdE, RD1E, RD2E, immediateE, CtrlE} = m_pay;

  // Handshake outputs decode only the state register, so neither depends on inputs.
  assign ValidE   = (state_q != EMPTY);
  assign ReadyD   = (state_q != FULL);
  assign in_fire  = ValidD & ReadyD;
  assign out_fire = ValidE & ReadyE;

  always_comb begin
    state_d     = state_q;
    load_m_in   = 1'b0;
    load_m_skid = 1'b0;
    load_s      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          load_m_in = 1'b1;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          load_m_in = 1'b1;
        end else if (in_fire) begin
          load_s  = 1'b1;
          state_d = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          load_m_skid = 1'b1;
          state_d     = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Flush wins over any simultaneous transfer; main payload is otherwise held while empty.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= EMPTY;
      m_pay   <= '0;
      s_pay   <= '0;
    end else if (FLUSH) begin
      state_q <= EMPTY;
      m_pay   <= '0;
      s_pay   <= '0;
    end else begin
      state_q <= state_d;
      if (load_m_in)
        m_pay <= in_pay;
      else if (load_m_skid)
        m_pay <= s_pay;
      if (load_s)
        s_pay <= in_pay;
    end
  end

`ifdef ID_EX_STATS_EN
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  // Counters ignore FLUSH so they reflect real pipeline activity across squashes.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      StatIssued <= '0;
      StatBubble <= '0;
      StatStall  <= '0;
    end else begin
      if (out_fire && (StatIssued != STAT_MAX))
        StatIssued <= StatIssued + 1'b1;
      if (!ValidE && (StatBubble != STAT_MAX))
        StatBubble <= StatBubble + 1'b1;
      if (ValidE && !ReadyE && (StatStall != STAT_MAX))
        StatStall <= StatStall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Scoreboard bench for id_ex_pipe_stage (64-bit data, 8-bit control build).
module tb_id_ex_pipe_stage;

  localparam int DATA_W = 64;
  localparam int REG_AW = 5;
  localparam int CTRL_W = 8;
  localparam int PW     = 3*REG_AW + 3*DATA_W + CTRL_W;

  logic              CLK = 1'b0;
  logic              RST_N, FLUSH, ValidD, ReadyE;
  logic              ReadyD, ValidE;
  logic [REG_AW-1:0] RsD, RtD, RdD, RsE, RtE, RdE;
  logic [DATA_W-1:0] RD1, RD2, immediateD, RD1E, RD2E, immediateE;
  logic [CTRL_W-1:0] CtrlD, CtrlE;
`ifdef ID_EX_STATS_EN
  logic [31:0]       StatIssued, StatBubble, StatStall;
  logic [1:0]        satIssued, satBubble, satStall;
  logic              satReadyD, satValidE;
  logic [REG_AW-1:0] satRsE, satRtE, satRdE;
  logic [DATA_W-1:0] satRD1E, satRD2E, satImmE;
  logic [CTRL_W-1:0] satCtrlE;
  logic [31:0]       mIssued, mBubble, mStall;
  logic [1:0]        mSatIssued, mSatBubble, mSatStall;
`endif

  always #5 CLK = ~CLK;

  id_ex_pipe_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CTRL_W(CTRL_W), .STAT_W(32)) dut (
    .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH), .ValidD(ValidD), .ReadyD(ReadyD),
    .RsD(RsD), .RtD(RtD), .RdD(RdD), .RD1(RD1), .RD2(RD2), .immediateD(immediateD),
    .CtrlD(CtrlD), .ValidE(ValidE), .ReadyE(ReadyE), .RsE(RsE), .RtE(RtE), .RdE(RdE),
    .RD1E(RD1E), .RD2E(RD2E), .immediateE(immediateE), .CtrlE(CtrlE)
`ifdef ID_EX_STATS_EN
    , .StatIssued(StatIssued), .StatBubble(StatBubble), .StatStall(StatStall)
`endif
  );

`ifdef ID_EX_STATS_EN
  id_ex_pipe_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CTRL_W(CTRL_W), .STAT_W(2)) dut_sat (
    .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH), .ValidD(ValidD), .ReadyD(satReadyD),
    .RsD(RsD), .RtD(RtD), .RdD(RdD), .RD1(RD1), .RD2(RD2), .immediateD(immediateD),
    .CtrlD(CtrlD), .ValidE(satValidE), .ReadyE(ReadyE), .RsE(satRsE), .RtE(satRtE),
    .RdE(satRdE), .RD1E(satRD1E), .RD2E(satRD2E), .immediateE(satImmE), .CtrlE(satCtrlE),
    .StatIssued(satIssued), .StatBubble(satBubble), .StatStall(satStall)
  );
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [PW-1:0] sbq[$];
  logic [PW-1:0] lastOut;

  task automatic checkOutput(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] mkPay(input logic [DATA_W-1:0] rd1,
                                          input logic [DATA_W-1:0] imm,
                                          input logic [CTRL_W-1:0] ctrl);
    logic [REG_AW-1:0] rs, rt, rd;
    logic [DATA_W-1:0] rd2;
    rs  = REG_AW'($urandom);
    rt  = REG_AW'($urandom);
    rd  = REG_AW'($urandom);
    rd2 = {$urandom, $urandom};
    return {rs, rt, rd, rd1, rd2, imm, ctrl};
  endfunction

  function automatic logic [PW-1:0] rndPay();
    return mkPay({$urandom, $urandom}, {$urandom, $urandom}, CTRL_W'($urandom));
  endfunction

  task automatic modelReset();
    sbq.delete();
    lastOut = '0;
`ifdef ID_EX_STATS_EN
    mIssued = '0; mBubble = '0; mStall = '0;
    mSatIssued = '0; mSatBubble = '0; mSatStall = '0;
`endif
  endtask

  task automatic checkState(input string tag);
    logic [PW-1:0] expPay;
    expPay = (sbq.size() > 0) ? sbq[0] : lastOut;
    checkOutput({tag, "_validE"}, PW'(ValidE), PW'(sbq.size() > 0));
    checkOutput({tag, "_readyD"}, PW'(ReadyD), PW'(sbq.size() < 2));
    checkOutput({tag, "_payload"}, {RsE, RtE, RdE, RD1E, RD2E, immediateE, CtrlE}, expPay);
`ifdef ID_EX_STATS_EN
    checkOutput({tag, "_statIssued"}, PW'(StatIssued), PW'(mIssued));
    checkOutput({tag, "_statBubble"}, PW'(StatBubble), PW'(mBubble));
    checkOutput({tag, "_statStall"}, PW'(StatStall), PW'(mStall));
    checkOutput({tag, "_satIssued"}, PW'(satIssued), PW'(mSatIssued));
    checkOutput({tag, "_satBubble"}, PW'(satBubble), PW'(mSatBubble));
    checkOutput({tag, "_satStall"}, PW'(satStall), PW'(mSatStall));
`endif
  endtask

  // Called at a falling edge: check current outputs, drive the next cycle, advance the model.
  task automatic applyStimulus(input string tag, input logic vd, input logic [PW-1:0] pay,
                               input logic re, input logic fl);
    logic outF, inF;
    checkState(tag);
    {RsD, RtD, RdD, RD1, RD2, immediateD, CtrlD} = pay;
    ValidD = vd;
    ReadyE = re;
    FLUSH  = fl;
    outF = (sbq.size() > 0) && re;
    inF  = vd && (sbq.size() < 2);
`ifdef ID_EX_STATS_EN
    if (sbq.size() == 0) begin
      if (mBubble != '1) mBubble++;
      if (mSatBubble != '1) mSatBubble++;
    end else if (!re) begin
      if (mStall != '1) mStall++;
      if (mSatStall != '1) mSatStall++;
    end
    if (outF) begin
      if (mIssued != '1) mIssued++;
      if (mSatIssued != '1) mSatIssued++;
    end
`endif
    if (fl) begin
      sbq.delete();
      lastOut = '0;
    end else begin
      if (outF) lastOut = sbq.pop_front();
      if (inF) sbq.push_back(pay);
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    RST_N = 1'b0; FLUSH = 1'b0; ValidD = 1'b0; ReadyE = 1'b0;
    {RsD, RtD, RdD, RD1, RD2, immediateD, CtrlD} = '0;
    modelReset();
    #1;
    checkState("reset");
    @(negedge CLK);
    RST_N = 1'b1;

    for (int i = 0; i < 3; i++) applyStimulus("idle", 1'b0, rndPay(), 1'b1, 1'b0);

    for (int i = 1; i <= 4; i++)
      applyStimulus("stream", 1'b1, mkPay(DATA_W'(8'h11 * i), {$urandom, $urandom}, 8'h0F), 1'b1, 1'b0);
    applyStimulus("drain", 1'b0, rndPay(), 1'b1, 1'b0);
    applyStimulus("drain", 1'b0, rndPay(), 1'b1, 1'b0);

    applyStimulus("bpA", 1'b1, mkPay(64'hA, 64'h1, 8'h1), 1'b0, 1'b0);
    applyStimulus("bpB", 1'b1, mkPay(64'hB, 64'h2, 8'h2), 1'b0, 1'b0);
    applyStimulus("bpIgnored", 1'b1, mkPay(64'hC, 64'h3, 8'h3), 1'b0, 1'b0);
    applyStimulus("bpHold", 1'b0, rndPay(), 1'b0, 1'b0);
    applyStimulus("bpFireA", 1'b0, rndPay(), 1'b1, 1'b0);
    applyStimulus("bpFireB", 1'b0, rndPay(), 1'b1, 1'b0);
    applyStimulus("bpDone", 1'b0, rndPay(), 1'b1, 1'b0);

    applyStimulus("flA", 1'b1, mkPay(64'hAA, 64'h1, 8'h1), 1'b0, 1'b0);
    applyStimulus("flB", 1'b1, mkPay(64'hBB, 64'h2, 8'h2), 1'b0, 1'b0);
    applyStimulus("flC", 1'b1, mkPay(64'hCC, 64'h3, 8'h3), 1'b0, 1'b1);
    checkOutput("flushRd1", PW'(RD1E), PW'(0));
    applyStimulus("postFlush", 1'b0, rndPay(), 1'b1, 1'b0);
    applyStimulus("postFlush", 1'b0, rndPay(), 1'b1, 1'b0);

    applyStimulus("preRst", 1'b1, mkPay(64'hD, 64'h4, 8'h4), 1'b0, 1'b0);
    ValidD = 1'b0;
    #2 RST_N = 1'b0;
    #1;
    modelReset();
    checkState("asyncRst");
    @(posedge CLK);
    #2 RST_N = 1'b1;
    @(negedge CLK);
    applyStimulus("rstPush", 1'b1, mkPay(64'hE, 64'h5, 8'h5), 1'b1, 1'b0);
    applyStimulus("rstOut", 1'b0, rndPay(), 1'b1, 1'b0);

    applyStimulus("wide", 1'b1, mkPay(64'h77, 64'hFFFF_0000_1234_5678, 8'hA5), 1'b0, 1'b0);
    applyStimulus("wideStall", 1'b0, rndPay(), 1'b0, 1'b0);
    checkOutput("wideImm", PW'(immediateE), PW'(64'hFFFF_0000_1234_5678));
    checkOutput("wideCtrl", PW'(CtrlE), PW'(8'hA5));
    applyStimulus("wideFire", 1'b0, rndPay(), 1'b1, 1'b0);

    for (int i = 0; i < 300; i++)
      applyStimulus("random", 1'($urandom_range(0, 3) != 0), rndPay(),
                    1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));

    checkState("final");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
